// File: rtl/dpll_sampler.sv
// dpll_sampler: DPLL LPF enable/latch strobes, offset-calibrated saturated sample capture with valid/ready handoff
module dpll_sampler #(
    parameter int DATA_W   = 32,
    parameter int LPF_USR  = 2,
    parameter int LTCH_DIV = 4096,
    parameter int LTCH_LAT = 1,
    parameter int CAL_SHR  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              lpf_en_o,
    output logic              lpf_ltch_o,
    input  logic [DATA_W-1:0] lpf_i,
    input  logic              cal_i,
    output logic              cal_busy_o,
    output logic [DATA_W-1:0] offs_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              ovr_o,
    input  logic              ovr_clr_i
);
    localparam int EW = LPF_USR > 1 ? $clog2(LPF_USR) : 1;
    localparam int LW = $clog2(LTCH_DIV);
    localparam int AW = DATA_W + CAL_SHR;
    localparam int NW = CAL_SHR + 1;
    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] ACC  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [EW-1:0]     en_cnt, en_nxt;
    logic [LW-1:0]     lt_cnt, lt_nxt;
    logic              smp;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] sat;
    logic [1:0]        state;
    logic [AW-1:0]     acc;
    logic [NW-1:0]     n;

    assign en_nxt = en_cnt == EW'(LPF_USR - 1) ? '0 : en_cnt + 1'b1;
    assign lt_nxt = lt_cnt == LW'(LTCH_DIV - 1) ? '0 : lt_cnt + 1'b1;

    // Strobes are registered so they are high exactly while their counter sits at the terminal count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_cnt     <= '0;
            lt_cnt     <= '0;
            lpf_en_o   <= 1'b0;
            lpf_ltch_o <= 1'b0;
        end else begin
            en_cnt     <= en_nxt;
            lt_cnt     <= lt_nxt;
            lpf_en_o   <= en_nxt == EW'(LPF_USR - 1);
            lpf_ltch_o <= lt_nxt == LW'(LTCH_DIV - 1);
        end
    end

    // Sample strobe: latch strobe delayed by the DPLL latch register latency
    generate
        if (LTCH_LAT == 0) begin : g_nolat
            assign smp = lpf_ltch_o;
        end else begin : g_lat
            logic [LTCH_LAT-1:0] sr;
            // Delay line for the latch strobe
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) sr <= '0;
                else       sr <= (sr << 1) | LTCH_LAT'(lpf_ltch_o);
            end
            assign smp = sr[LTCH_LAT-1];
        end
    endgenerate

    // Overflow of the widened difference shows as disagreement of its top two bits
    assign diff = {1'b0, lpf_i} - {1'b0, offs_o};
    assign sat  = diff[DATA_W] != diff[DATA_W-1] ? {diff[DATA_W], {(DATA_W-1){~diff[DATA_W]}}} : diff[DATA_W-1:0];

    // Output register with handshake; a new sample into an unaccepted slot flags overrun, set beats clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            ovr_o   <= 1'b0;
        end else begin
            if (smp) data_o <= sat;
            valid_o <= smp | (valid_o & ~ready_i);
            ovr_o   <= (smp & valid_o & ~ready_i) | (ovr_o & ~ovr_clr_i);
        end
    end

    assign cal_busy_o = state != RUN;

    // Calibration: average 2**CAL_SHR consecutive samples, then publish as the new offset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= RUN;
            acc    <= '0;
            n      <= '0;
            offs_o <= '0;
        end else begin
            case (state)
                RUN: if (cal_i) state <= ARM;
                ARM: if (smp) begin
                    acc   <= AW'(lpf_i);
                    n     <= NW'(1);
                    state <= CAL_SHR == 0 ? DONE : ACC;
                end
                ACC: if (smp) begin
                    acc <= acc + AW'(lpf_i);
                    n   <= n + 1'b1;
                    if (n == NW'(2 ** CAL_SHR - 1)) state <= DONE;
                end
                default: begin
                    offs_o <= DATA_W'(acc >> CAL_SHR);
                    state  <= RUN;
                end
            endcase
        end
    end
endmodule
